// File: rtl/reg_wb_pkg.sv
// Shared widths, queue entry type and sizing helper for the register write-back queue.
package reg_wb_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned AddrW = 4;

  typedef struct packed {
    logic [AddrW-1:0] dest;
    logic [DataW-1:0] data;
  } wb_entry_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_wb_match.sv
// Forwarding lookup: finds the youngest valid queue entry whose destination matches a query index.
module reg_wb_match
  import reg_wb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  wb_entry_t        entries_i [Depth],
  input  logic [Depth-1:0] valid_i,
  input  logic [PtrW-1:0]  rd_ptr_i,
  input  logic [AddrW-1:0] src_i,
  output logic             hit_o,
  output logic [DataW-1:0] fwd_o
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest starting at the head; later matches overwrite earlier ones.
  always_comb begin
    hit_o = 1'b0;
    fwd_o = '0;
    idx   = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      idx = rd_ptr_i + PtrW'(i);
      if (valid_i[idx] && (entries_i[idx].dest == src_i)) begin
        hit_o = 1'b1;
        fwd_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order write-back queue feeding the register file write port, with operand forwarding.
module reg_writeback_queue
  import reg_wb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = cnt_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alu_valid_i,
  input  logic [AddrW-1:0] alu_dest_i,
  input  logic [DataW-1:0] alu_data_i,
  output logic             alu_ready_o,
  input  logic             mem_valid_i,
  input  logic [AddrW-1:0] mem_dest_i,
  input  logic [DataW-1:0] mem_data_i,
  output logic             mem_ready_o,
  output logic             wr_en_o,
  output logic [AddrW-1:0] wr_dest_o,
  output logic [DataW-1:0] wr_data_o,
  input  logic [AddrW-1:0] src1_i,
  input  logic [AddrW-1:0] src2_i,
  output logic             hit1_o,
  output logic             hit2_o,
  output logic [DataW-1:0] fwd1_o,
  output logic [DataW-1:0] fwd2_o,
  output logic [CntW-1:0]  count_o
);

  wb_entry_t        entries_q [Depth];
  wb_entry_t        entries_d [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  alu_slot;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, room_for_two;
  logic             mem_acc, alu_acc, pop;

  // Ready depends only on occupancy at the start of the cycle (plus mem_valid for ALU priority).
  assign full         = (count_q == CntW'(Depth));
  assign room_for_two = (count_q <= CntW'(Depth - 2));
  assign mem_ready_o  = ~full;
  assign alu_ready_o  = mem_valid_i ? room_for_two : ~full;

  assign mem_acc  = mem_valid_i & mem_ready_o;
  assign alu_acc  = alu_valid_i & alu_ready_o;
  assign pop      = (count_q != '0);
  assign alu_slot = wr_ptr_q + PtrW'(mem_acc);

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
    end
    // The mem result is older than a same-cycle ALU result, so it takes the lower slot.
    if (mem_acc) begin
      entries_d[wr_ptr_q] = '{dest: mem_dest_i, data: mem_data_i};
      valid_d[wr_ptr_q]   = 1'b1;
    end
    if (alu_acc) begin
      entries_d[alu_slot] = '{dest: alu_dest_i, data: alu_data_i};
      valid_d[alu_slot]   = 1'b1;
    end
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(mem_acc) + PtrW'(alu_acc);
    count_d  = count_q + CntW'(mem_acc) + CntW'(alu_acc) - CntW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: every consumer is gated by valid_q or count_q.
  always_ff @(posedge clk_i) begin
    entries_q <= entries_d;
  end

  assign wr_en_o   = pop;
  assign wr_dest_o = pop ? entries_q[rd_ptr_q].dest : '0;
  assign wr_data_o = pop ? entries_q[rd_ptr_q].data : '0;
  assign count_o   = count_q;

  reg_wb_match #(
    .Depth (Depth)
  ) u_match1 (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .rd_ptr_i  (rd_ptr_q),
    .src_i     (src1_i),
    .hit_o     (hit1_o),
    .fwd_o     (fwd1_o)
  );

  reg_wb_match #(
    .Depth (Depth)
  ) u_match2 (
    .entries_i (entries_q),
    .valid_i   (valid_q),
    .rd_ptr_i  (rd_ptr_q),
    .src_i     (src2_i),
    .hit_o     (hit2_o),
    .fwd_o     (fwd2_o)
  );

endmodule
